led_mode_ctrl: RTL
==================

// Module: led_mode_ctrl
// PURPOSE
//   Parametrised multi-channel LED driver for the iCE40 top level, clocked from the SB_HFOSC clock.
//   Each channel has a 2-bit mode from the operate pins: off, solid on, blink or PWM dim.
//   Mode and duty inputs change only at a PWM period boundary, so the output never shows a runt pulse.
//   Outputs are registered, with selectable polarity for active-low board LEDs.
// PARAMETERS
//   N_CH       2    number of LED channels
//   PWM_W      8    PWM counter/duty width; PWM period = 2^PWM_W ticks
//   PRESC      1    clk cycles per PWM tick (>=1); prescaler width = max(1,$clog2(PRESC))
//   BLINK_W    8    blink counter width; counts PWM periods; blink phase = MSB
//   ACTIVE_LOW 0    1: led pin driven low when the LED is lit
// PORTS
//   clk      in   1           system clock (SB_HFOSC CLKHF)
//   rst_n    in   1           synchronous active-low reset
//   operate  in   2*N_CH      per-channel mode, ch i = operate[2i+1:2i]; asynchronous pins
//   duty     in   PWM_W*N_CH  per-channel PWM duty, ch i = duty[PWM_W*i +: PWM_W]; synchronous to clk
//   led      out  N_CH        LED pins, registered
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge): prescaler, pwm_cnt, blink_cnt, sync flops, mode_q and duty_q all go to 0.
//     The value 0 selects OFF, so led goes to the off level: {N_CH{ACTIVE_LOW}}.
//     Reset overrides every other event in the same cycle.
//   Sync: operate passes through a 2-flop synchronizer per bit (op_s). The value reaches op_s 2 cycles after the pin changes.
//   Tick: tick=1 when prescaler==PRESC-1; the prescaler then wraps to 0. With PRESC=1, tick is always 1.
//   pwm_cnt: increments on each tick and wraps from 2^PWM_W-1 to 0.
//   wrap = tick && pwm_cnt==2^PWM_W-1.
//   blink_cnt: increments on wrap and wraps modulo 2^BLINK_W. It is free-running and is not reset on a mode change.
//   Period boundary: on a wrap edge, mode_q[i] <= op_s[i] and duty_q[i] <= duty[i].
//     These are the only edges where mode_q and duty_q update.
//     Worst-case mode latency = 2 + PRESC*2^PWM_W cycles.
//   Per-channel lit value, computed from the state in the current cycle; led registers it at the next edge:
//     OFF   2'b00  lit=0
//     ON    2'b01  lit=1
//     BLINK 2'b10  lit = ~blink_cnt[BLINK_W-1], i.e. a 50% square wave with period PRESC*2^(PWM_W+BLINK_W)
//     PWM   2'b11  lit = (pwm_cnt < duty_q), unsigned compare
//   Polarity: led[i] <= lit ^ ACTIVE_LOW.
//   Duty boundaries: duty 0 -> never lit. duty 2^PWM_W-1 -> lit for 2^PWM_W-1 of 2^PWM_W ticks (never 100%; use ON for that).
//   duty changes mid-period are ignored until the next boundary.
//   Channels are independent. All channels share the prescaler, pwm_cnt and blink_cnt, so their PWM and blink edges are phase-aligned.
//   Reset mid-period: led is at the off level on the edge after rst_n is sampled low.
//     After rst_n rises, all channels are OFF until the first wrap, which falls at reset-exit + PRESC*2^PWM_W cycles.
// STRUCTURE
//   Shared package/include led_mode_pkg:
//     localparams LED_OFF=2'b00, LED_ON=2'b01, LED_BLINK=2'b10, LED_PWM=2'b11.
//   Top level holds the synchronizer, prescaler, pwm_cnt, blink_cnt and wrap generation.
//   Sub-module led_pwm_channel (one per channel, generate loop):
//     holds mode_q and duty_q; computes lit; registers led bit.
//     inputs: clk, rst_n, wrap, pwm_cnt, blink_msb, op_s, duty.
// TESTING  (N_CH=2, PWM_W=4, PRESC=1, BLINK_W=3, ACTIVE_LOW=0 unless stated)
//   1 Reset: operate=4'b1111, duty=8'hFF, rst_n=0 for 4 cycles
//       -> led=2'b00, pwm_cnt=0. After release, led stays 00 for 16 cycles.
//   2 Solid on/off: operate=4'b0001
//       -> led[0]=1 steady from the first wrap after the 2-cycle sync; led[1]=0 throughout.
//   3 PWM: ch0 PWM with duty 4 -> led[0] high for exactly 4 of every 16 cycles.
//       Repeat with duty 0 -> always 0, and duty 15 -> high for 15 of 16.
//   4 Blink: ch1 operate=2'b10
//       -> led[1] alternates 64-cycle high and 64-cycle low runs, aligned to wrap edges.
//   5 Mid-period switch: ch0 PWM duty 8; at pwm_cnt=3 set operate to ON and duty to 2
//       -> no led change until the next wrap; then led[0]=1 continuously. No pulse shorter than 8 cycles.
//   6 Reset mid-pulse, ACTIVE_LOW=1: ch0 in PWM and lit (led[0]=0); rst_n=0 for 1 cycle
//       -> led[0]=1 on the next edge; all counters 0; OFF until the next wrap.

Source files
------------

// File: rtl/led_mode_pkg.sv
// ---------------------------------------------------------------------------
// led_mode_pkg
//   Shared definitions for the LED mode controller: the 2-bit per-channel
//   mode encodings carried on the operate pins and held in each channel.
//   No ports; imported by led_mode_ctrl and led_pwm_channel.
// ---------------------------------------------------------------------------
package led_mode_pkg;

  localparam int MODE_W = 2;

  // Mode encodings. The all-zero value is OFF so that a cleared mode
  // register naturally leaves the LED dark.
  localparam logic [MODE_W-1:0] LED_OFF   = 2'b00;
  localparam logic [MODE_W-1:0] LED_ON    = 2'b01;
  localparam logic [MODE_W-1:0] LED_BLINK = 2'b10;
  localparam logic [MODE_W-1:0] LED_PWM   = 2'b11;

endpackage

// File: rtl/led_pwm_channel.sv
// ---------------------------------------------------------------------------
// led_pwm_channel
//   One LED channel. Captures its mode and duty only at PWM period
//   boundaries, derives the lit state from the shared counters and
//   registers the polarity-corrected pin value.
// Ports
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   wrap       in   1-cycle strobe on the last tick of a PWM period
//   pwm_cnt    in   shared PWM position counter
//   blink_msb  in   MSB of the shared blink counter (blink phase)
//   op_s       in   synchronized 2-bit mode for this channel
//   duty       in   duty value for this channel
//   led        out  registered LED pin
// ---------------------------------------------------------------------------
module led_pwm_channel
  import led_mode_pkg::*;
#(
  parameter int PWM_W      = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrap,
  input  logic [PWM_W-1:0]  pwm_cnt,
  input  logic              blink_msb,
  input  logic [MODE_W-1:0] op_s,
  input  logic [PWM_W-1:0]  duty,
  output logic              led
);

  localparam logic OFF_LEVEL = (ACTIVE_LOW != 0);

  logic [MODE_W-1:0] mode_q;
  logic [PWM_W-1:0]  duty_q;
  logic              lit;

  // Mode and duty are only taken on the wrap edge, so a change can never
  // cut a PWM or blink pulse short partway through a period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= LED_OFF;
      duty_q <= '0;
    end else if (wrap) begin
      mode_q <= op_s;
      duty_q <= duty;
    end
  end

  // Blink is lit during the low half of the blink phase; PWM is lit while
  // the period position is below the duty, so duty 0 is always dark and
  // the maximum duty still leaves one dark tick.
  always_comb begin
    lit = 1'b0;
    case (mode_q)
      LED_OFF:   lit = 1'b0;
      LED_ON:    lit = 1'b1;
      LED_BLINK: lit = ~blink_msb;
      LED_PWM:   lit = (pwm_cnt < duty_q);
      default:   lit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led <= OFF_LEVEL;
    end else begin
      led <= lit ^ OFF_LEVEL;
    end
  end

endmodule

// File: rtl/led_mode_ctrl.sv
// ---------------------------------------------------------------------------
// led_mode_ctrl
//   Multi-channel LED driver: off / solid on / blink / PWM dim per channel.
//   Holds the operate-pin synchronizer and the time base (prescaler, PWM
//   position, blink counter) shared by every channel, so all channels'
//   PWM and blink edges are phase-aligned.
// Ports
//   clk      in   system clock (SB_HFOSC CLKHF)
//   rst_n    in   synchronous active-low reset
//   operate  in   2 bits per channel, ch i = operate[2i+1:2i]; asynchronous
//   duty     in   PWM_W bits per channel, ch i = duty[PWM_W*i +: PWM_W]
//   led      out  one registered LED pin per channel
// ---------------------------------------------------------------------------
module led_mode_ctrl
  import led_mode_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int PWM_W      = 8,
  parameter int PRESC      = 1,
  parameter int BLINK_W    = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [MODE_W*N_CH-1:0]  operate,
  input  logic [PWM_W*N_CH-1:0]   duty,
  output logic [N_CH-1:0]         led
);

  localparam int PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);

  logic [MODE_W*N_CH-1:0] op_meta;
  logic [MODE_W*N_CH-1:0] op_s;
  logic [PRESC_W-1:0]     prescaler;
  logic [PWM_W-1:0]       pwm_cnt;
  logic [BLINK_W-1:0]     blink_cnt;
  logic                   tick;
  logic                   wrap;
  logic                   blink_msb;

  // The operate pins come from off-chip with no clock relationship, so each
  // bit passes through two flops before any channel looks at it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_meta <= '0;
      op_s    <= '0;
    end else begin
      op_meta <= operate;
      op_s    <= op_meta;
    end
  end

  // With PRESC=1 the prescaler sits at 0 and every cycle is a tick.
  assign tick = (prescaler == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PRESC_W'(1);
    end
  end

  // wrap marks the last tick of a PWM period; it is the only moment the
  // channels may adopt new settings and the only time blink_cnt advances.
  assign wrap      = tick && (&pwm_cnt);
  assign blink_msb = blink_cnt[BLINK_W-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt   <= '0;
      blink_cnt <= '0;
    end else begin
      if (tick) begin
        pwm_cnt <= pwm_cnt + PWM_W'(1);
      end
      if (wrap) begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_pwm_channel #(
      .PWM_W      (PWM_W),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .wrap      (wrap),
      .pwm_cnt   (pwm_cnt),
      .blink_msb (blink_msb),
      .op_s      (op_s[MODE_W*i +: MODE_W]),
      .duty      (duty[PWM_W*i +: PWM_W]),
      .led       (led[i])
    );
  end

endmodule
